tristate_bus_ctrl: RTL
======================

// Module: tristate_bus_ctrl
// PURPOSE
//  Owner/sampler end of a shared tri-state bus. Up to N drivers each gate the bus through their own
//  tristate buffer. This block issues their one-hot output enables with round-robin fairness and a
//  forced all-off turnaround gap between owners. It also registers the bus value on every owned cycle.
//  It sits beside the bus; it never drives the data lines itself.
// PARAMETERS
//  N_DRV      4   number of tristate drivers on the bus (2..16)
//  WIDTH      8   bus data width
//  TURNAROUND 1   all-oe-low cycles between two ownerships (>=1)
//  MAX_HOLD   16  max consecutive owned cycles before forced release (>=1)
// PORTS
//  clk       in   1                rising-edge clock
//  rst       in   1                synchronous, active-high reset
//  req       in   N_DRV            per-driver bus request, level, held until served
//  oe        out  N_DRV            per-driver tristate enable, one-hot or zero, registered
//  grant_id  out  $clog2(N_DRV)    index of current owner, valid while |oe
//  bus       in   WIDTH            resolved bus value (read only)
//  rx_data   out  WIDTH            sampled bus data
//  rx_valid  out  1                rx_data holds data from an owned cycle
//  rx_src    out  $clog2(N_DRV)    driver index that produced rx_data
//  bus_idle  out  1                no owner and no turnaround in progress
// BEHAVIOUR
//  - Reset: oe=0, grant_id=0, rx_data=0, rx_valid=0, rx_src=0, bus_idle=1, state=IDLE, rr pointer=0.
//  - FSM IDLE -> OWN -> TURN -> IDLE.
//  - IDLE: if |req, pick the first set req at or after ptr (wrapping N_DRV-1 -> 0).
//    Next edge: oe[pick]=1, grant_id=pick, ptr=pick+1 (mod N_DRV), hold counter=1, go OWN.
//    Result: req seen at edge k gives oe high after edge k+1.
//  - OWN: oe unchanged. Count owned cycles.
//    Exit to TURN when req[owner] is low or the count reaches MAX_HOLD, whichever comes first.
//    Next edge after exit: oe=0.
//  - TURN: oe=0 for exactly TURNAROUND cycles, then IDLE. A pending req is evaluated in that
//    IDLE cycle. Minimum gap between two owners' oe is therefore TURNAROUND+1 cycles.
//  - Sampling: on every edge where oe was nonzero in the preceding cycle, rx_data<=bus,
//    rx_src<=grant_id, rx_valid<=1. Otherwise rx_valid<=0 and rx_data holds.
//    Result: one-cycle latency from an owned cycle to its rx_valid pulse.
//  - bus_idle=1 only in IDLE. It is registered with the state.
//  - Invariants: $countones(oe)<=1 always. oe never changes from one driver straight to another
//    without >=TURNAROUND zero cycles.
//  - Boundaries:
//    - All req set: owners rotate 0,1,2,3,0... each for up to MAX_HOLD cycles.
//    - Single requester holding req forever: it is released at MAX_HOLD, gets TURNAROUND gap,
//      then is re-granted.
//    - req dropped during TURN: ignored.
//    - req of non-owner changes during OWN: no effect until IDLE.
//    - rst asserted in any state: all outputs take reset values at that edge, including oe=0 mid-OWN.
//      The in-flight sample is discarded.
//    - Bus X/Z during an owned cycle is sampled as-is. No checking.
// STRUCTURE
//  - Package tristate_bus_pkg: state enum {IDLE, OWN, TURN}, localparam ID_W=$clog2(N_DRV),
//    hold/turn counter widths.
//  - Sub-module rr_pick (combinational round-robin picker: req, ptr -> pick, any).
//    Rest is FSM + counters + sample regs in this file.
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111
//     -> oe=0, rx_valid=0, bus_idle=1 throughout; first grant to driver 0 two edges after rst falls.
//  2. Single grant: req=4'b0100 held 3 cycles, bus=8'hA5
//     -> oe=4'b0100 for 3 cycles, grant_id=2, three rx_valid pulses with rx_data=A5, rx_src=2,
//        then oe=0 for 1 cycle.
//  3. Fairness: req=4'b1111 held, MAX_HOLD=2
//     -> owners 0,1,2,3,0, each 2 cycles of oe, each separated by exactly 2 oe=0 cycles;
//        never two oe bits set.
//  4. Starvation guard: req=4'b0001 held 40 cycles
//     -> oe[0] high 16 cycles, low 2 cycles, high 16, ...
//  5. Mid-grant reset: rst pulsed on 2nd owned cycle of driver 1
//     -> oe=0 and rx_valid=0 at that edge; ptr=0, so next grant goes to lowest set req.
//  6. Wrap: ptr=3, req=4'b1001
//     -> driver 3 served, then driver 0; TURNAROUND=3 gives 4 zero-oe cycles between them.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Shared types and default sizing for the tri-state bus owner/sampler.
package tristate_bus_pkg;

    // Bus ownership phases: nobody owns, one driver owns, forced all-off gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // Default configuration of the block.
    localparam int N_DRV_DEF      = 4;
    localparam int WIDTH_DEF      = 8;
    localparam int TURNAROUND_DEF = 1;
    localparam int MAX_HOLD_DEF   = 16;

    // Width of a driver index and of the hold/turnaround counters.
    localparam int ID_W   = $clog2(N_DRV_DEF);
    localparam int HOLD_W = $clog2(MAX_HOLD_DEF + 1);
    localparam int TURN_W = $clog2(TURNAROUND_DEF + 1);

    // Bits needed for a counter that must reach max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tristate_bus_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from the highest index back to 0.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] pick,
    output logic            any
);

    int idx;

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_ctrl.sv
// Owner/sampler end of a shared tri-state bus: issues one-hot output enables
// with round-robin fairness, a forced all-off turnaround between owners, and
// registers the bus value on every owned cycle. Never drives the data lines.
//
// Handshake: req[i] is a level request that driver i holds until it is served;
// oe[i] is the grant and the tristate enable at once. A driver may only put
// data on the bus while its oe is high, and dropping req releases the bus at
// the next edge. There is no backpressure on the sampled side: rx_valid is a
// one-cycle pulse that a consumer must take when it appears.
module tristate_bus_ctrl
    import tristate_bus_pkg::*;
#(
    parameter int N_DRV      = N_DRV_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF,
    parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DRV-1:0]         req,
    output logic [N_DRV-1:0]         oe,
    output logic [$clog2(N_DRV)-1:0] grant_id,
    input  logic [WIDTH-1:0]         bus,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    output logic [$clog2(N_DRV)-1:0] rx_src,
    output logic                     bus_idle,
    output logic [1:0]               dbg_state
);

    localparam int DRV_W   = $clog2(N_DRV);
    localparam int CNT_H_W = cnt_w(MAX_HOLD);
    localparam int CNT_T_W = cnt_w(TURNAROUND);

    state_t               state;
    logic [DRV_W-1:0]     ptr;
    logic [CNT_H_W-1:0]   hold_cnt;
    logic [CNT_T_W-1:0]   turn_cnt;
    logic [DRV_W-1:0]     pick;
    logic                 any_req;
    logic                 release_now;

    rr_pick #(
        .N    (N_DRV),
        .ID_W (DRV_W)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any_req)
    );

    // The owner gives up the bus when it stops asking or has used its quota.
    assign release_now = !req[grant_id] || (hold_cnt == CNT_H_W'(MAX_HOLD));

    assign dbg_state = state;

    // Ownership FSM with registered enables, owner id, pointer and idle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            oe       <= '0;
            grant_id <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            bus_idle <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        oe       <= {{(N_DRV-1){1'b0}}, 1'b1} << pick;
                        grant_id <= pick;
                        ptr      <= (pick == DRV_W'(N_DRV - 1)) ? '0 : pick + 1'b1;
                        hold_cnt <= CNT_H_W'(1);
                        bus_idle <= 1'b0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        oe       <= '0;
                        turn_cnt <= CNT_T_W'(1);
                        state    <= TURN;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    // Requests are not looked at here; the IDLE cycle that
                    // follows adds one more all-off cycle before any new owner.
                    if (turn_cnt == CNT_T_W'(TURNAROUND)) begin
                        bus_idle <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    oe       <= '0;
                    bus_idle <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Capture the bus one edge after every owned cycle; hold data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_src   <= '0;
            rx_valid <= 1'b0;
        end else if (|oe) begin
            rx_data  <= bus;
            rx_src   <= grant_id;
            rx_valid <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
        end
    end

endmodule
